// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the APB3 to Wishbone-style bridge.
package apb_bridge_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} apb_state_e;
  localparam int ACK_FIXED     = 0;
  localparam int ACK_HANDSHAKE = 1;
endpackage

// File: rtl/apb_bridge_timer.sv
// Saturating 8-bit wait/timeout counter for the bridge WAIT state.
module apb_bridge_timer
  import apb_bridge_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 16
)(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic wait_done,
  output logic timeout
);
  localparam logic [7:0] LP_WAIT = 8'(WAIT_STATES);
  localparam logic [7:0] LP_TO   = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;

  // Saturates at 8'hFF so an oversized WAIT_STATES can never wrap to an early match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_cnt <= '0;
    else if (clr)                    r_cnt <= '0;
    else if (en && r_cnt != 8'hFF)   r_cnt <= r_cnt + 8'd1;
  end

  assign wait_done = (r_cnt == LP_WAIT);
  assign timeout   = (r_cnt == LP_TO);
endmodule

// File: rtl/apb_wb_bridge.sv
// APB3 slave front-end issuing single-cycle read/write strobes to a peripheral core,
// with fixed-latency or ack-based completion, PSLVERR and backend timeout.
module apb_wb_bridge
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int ACK_MODE    = ACK_FIXED,
  parameter int WAIT_STATES = 0,
  parameter int TIMEOUT     = 16
)(
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [ADDR_W-1:0] adr_o,
  output logic [DATA_W-1:0] dat_o,
  output logic              we_o,
  output logic              re_o,
  input  logic              ack_i,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              err_i
);
  apb_state_e r_state;
  logic       r_dir;
  logic       w_clr, w_en, w_wait_done, w_timeout, w_cmpl, w_to_err;

  // Ack beats timeout when both land on the same edge.
  assign w_cmpl   = (ACK_MODE == ACK_HANDSHAKE) ? (ack_i | w_timeout) : w_wait_done;
  assign w_to_err = (ACK_MODE == ACK_HANDSHAKE) && !ack_i && w_timeout;
  assign w_clr    = (r_state == SETUP) && PSEL && PENABLE;
  assign w_en     = (r_state == WAIT) && PSEL && !w_cmpl;

  apb_bridge_timer #(
    .WAIT_STATES (WAIT_STATES),
    .TIMEOUT     (TIMEOUT)
  ) u_timer (
    .clk       (PCLK),
    .rst       (PRESET),
    .clr       (w_clr),
    .en        (w_en),
    .wait_done (w_wait_done),
    .timeout   (w_timeout)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= IDLE;
      r_dir   <= 1'b0;
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      adr_o   <= '0;
      dat_o   <= '0;
      we_o    <= 1'b0;
      re_o    <= 1'b0;
    end else begin
      we_o <= 1'b0;
      re_o <= 1'b0;
      case (r_state)
        IDLE: if (PSEL && !PENABLE) begin
          adr_o <= PADDR;
          r_dir <= PWRITE;
          if (PWRITE) dat_o <= PWDATA;
          r_state <= SETUP;
        end
        SETUP: begin
          if (!PSEL) r_state <= IDLE;
          else if (PENABLE) begin
            we_o    <= r_dir;
            re_o    <= !r_dir;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          // A dropped PSEL is a master abort; it overrides any completion.
          if (!PSEL) r_state <= IDLE;
          else if (w_cmpl) begin
            PREADY  <= 1'b1;
            PSLVERR <= w_to_err ? 1'b1 : err_i;
            if (!r_dir) PRDATA <= w_to_err ? '0 : dat_i;
            r_state <= DONE;
          end
        end
        DONE: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_wb_bridge.sv
// Scoreboard bench: three bridge instances (fixed WS=0, fixed WS=3, ack mode TIMEOUT=16).
module tb_apb_wb_bridge;
  typedef struct {int k; bit we; logic [4:0] adr; logic [31:0] dat;} stb_t;
  typedef struct {int k; bit rd; logic [31:0] rdata; bit err;} rsp_t;

  logic clk = 1'b0;
  logic PRESET;
  logic penable, pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic [2:0] psel, ack, err, we, re, pready, pslverr;
  logic [2:0][31:0] dati, prdata, dato;
  logic [2:0][4:0]  adr;

  int checks = 0, failures = 0;
  stb_t sq[$];
  rsp_t rq[$];
  logic [31:0] last_rd [3];
  stb_t s_m;
  rsp_t r_m;

  always #5 clk = ~clk;

  apb_wb_bridge #(.ACK_MODE(0), .WAIT_STATES(0)) u_a (
    .PCLK(clk), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
    .adr_o(adr[0]), .dat_o(dato[0]), .we_o(we[0]), .re_o(re[0]),
    .ack_i(ack[0]), .dat_i(dati[0]), .err_i(err[0]));
  apb_wb_bridge #(.ACK_MODE(0), .WAIT_STATES(3)) u_b (
    .PCLK(clk), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
    .adr_o(adr[1]), .dat_o(dato[1]), .we_o(we[1]), .re_o(re[1]),
    .ack_i(ack[1]), .dat_i(dati[1]), .err_i(err[1]));
  apb_wb_bridge #(.ACK_MODE(1), .TIMEOUT(16)) u_c (
    .PCLK(clk), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]),
    .adr_o(adr[2]), .dat_o(dato[2]), .we_o(we[2]), .re_o(re[2]),
    .ack_i(ack[2]), .dat_i(dati[2]), .err_i(err[2]));

  // Monitor: every strobe and every PREADY must match the next queued expectation.
  always @(negedge clk) begin
    if (!PRESET) begin
      for (int k = 0; k < 3; k++) begin
        if (we[k] || re[k]) begin
          checks++;
          if (sq.size() == 0) begin
            failures++;
            $display("FAIL strobe_unexp dut%0d: got we=%b re=%b, required none", k, we[k], re[k]);
          end else begin
            s_m = sq.pop_front();
            if (s_m.k != k || we[k] != s_m.we || re[k] != !s_m.we || adr[k] != s_m.adr ||
                (s_m.we && dato[k] != s_m.dat)) begin
              failures++;
              $display("FAIL strobe dut%0d: got we=%b re=%b adr=%h dat=%h, required dut%0d we=%b adr=%h dat=%h",
                       k, we[k], re[k], adr[k], dato[k], s_m.k, s_m.we, s_m.adr, s_m.dat);
            end
          end
        end
        if (pready[k]) begin
          checks++;
          if (rq.size() == 0) begin
            failures++;
            $display("FAIL pready_unexp dut%0d: got PREADY=1, required 0", k);
          end else begin
            r_m = rq.pop_front();
            if (r_m.k != k || pslverr[k] != r_m.err || prdata[k] != r_m.rdata) begin
              failures++;
              $display("FAIL response dut%0d: got PSLVERR=%b PRDATA=%h, required dut%0d PSLVERR=%b PRDATA=%h",
                       k, pslverr[k], prdata[k], r_m.k, r_m.err, r_m.rdata);
            end
          end
        end else if (pslverr[k]) begin
          checks++;
          failures++;
          $display("FAIL pslverr_alone dut%0d: got PSLVERR=1 with PREADY=0, required 0", k);
        end
      end
    end
  end

  task automatic check_reset(input string nm);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({pready[k], pslverr[k], we[k], re[k]} != 4'b0 || prdata[k] != 0 || adr[k] != 0 || dato[k] != 0) begin
        failures++;
        $display("FAIL %s dut%0d: got rdy=%b err=%b we=%b re=%b prdata=%h adr=%h dat=%h, required all 0",
                 nm, k, pready[k], pslverr[k], we[k], re[k], prdata[k], adr[k], dato[k]);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      psel = '0; penable = 1'b0; ack = '0; err = '0;
    end
  endtask

  // Full APB transfer; ack_at = edges after the access edge at which ack_i is sampled (0 = never).
  task automatic xfer(input int k, input bit wr, input logic [4:0] a, input logic [31:0] d,
                      input logic [31:0] rdat, input bit e, input int ack_at, input int exp_lat,
                      input logic [31:0] exp_rdata, input bit exp_err);
    int n;
    @(negedge clk);
    sq.push_back('{k, wr, a, d});
    rq.push_back('{k, !wr, wr ? last_rd[k] : exp_rdata, exp_err});
    if (!wr) last_rd[k] = exp_rdata;
    psel = '0; psel[k] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    dati[k] = rdat; err[k] = e;
    @(posedge clk);
    @(negedge clk); penable = 1'b1;
    @(posedge clk);
    n = 0;
    forever begin
      @(negedge clk);
      if (pready[k]) break;
      if (n >= 40) break;
      ack[k] = (n + 1 == ack_at);
      @(posedge clk);
      n++;
    end
    ack[k] = 1'b0;
    checks++;
    if (n != exp_lat) begin
      failures++;
      $display("FAIL latency dut%0d adr=%h: got %0d cycles, required %0d", k, a, n, exp_lat);
    end
    @(posedge clk);
  endtask

  initial begin
    PRESET = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    ack = '0; err = '0; dati = '0;
    for (int k = 0; k < 3; k++) last_rd[k] = '0;
    #2 check_reset("reset_init");
    repeat (2) @(negedge clk);
    PRESET = 1'b0;

    // fixed latency, no wait states; then back-to-back writes and an erroring read
    xfer(0, 1, 5'h03, 32'h0000_00A5, 32'h0, 0, 0, 1, 32'h0, 0);
    idle(2);
    xfer(0, 1, 5'h11, 32'h1111_0000, 32'h0, 0, 0, 1, 32'h0, 0);
    xfer(0, 1, 5'h1F, 32'hFFFF_0002, 32'h0, 0, 0, 1, 32'h0, 0);
    idle(1);
    xfer(0, 0, 5'h04, 32'h0, 32'h5555_AAAA, 1, 0, 1, 32'h5555_AAAA, 1);
    idle(1);

    // three wait states: read then write, PRDATA holds the read value
    xfer(1, 0, 5'h08, 32'h0, 32'h0000_1234, 0, 0, 4, 32'h0000_1234, 0);
    xfer(1, 1, 5'h09, 32'h0000_BEEF, 32'h0, 0, 0, 4, 32'h0, 0);
    idle(1);
    checks++;
    if (prdata[1] != 32'h0000_1234) begin
      failures++;
      $display("FAIL prdata_hold: got %h, required 00001234", prdata[1]);
    end

    // ack mode: ack with error 4 cycles after strobe, then a timeout
    xfer(2, 0, 5'h07, 32'h0, 32'hCAFE_0001, 1, 4, 4, 32'hCAFE_0001, 1);
    idle(1);
    xfer(2, 0, 5'h0A, 32'h0, 32'hDEAD_BEEF, 0, 0, 16, 32'h0, 1);
    @(negedge clk); psel = '0; penable = 1'b0; ack[2] = 1'b1;
    repeat (3) @(negedge clk);
    ack[2] = 1'b0;

    // master abort in WAIT with ack arriving: strobe only, no PREADY
    @(negedge clk);
    sq.push_back('{2, 1'b0, 5'h0C, 32'h0});
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 5'h0C;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); psel = '0; penable = 1'b0; ack[2] = 1'b1;
    repeat (3) @(negedge clk);
    ack[2] = 1'b0;
    idle(2);

    // protocol violations on the zero-wait instance, then recovery
    @(negedge clk); psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 5'h15; pwdata = 32'h99;
    repeat (3) @(negedge clk);
    psel = '0; penable = 1'b0;
    @(negedge clk); psel[0] = 1'b1; penable = 1'b0;
    @(negedge clk); psel = '0;
    idle(3);
    xfer(0, 1, 5'h06, 32'h0606_0606, 32'h0, 0, 0, 1, 32'h0, 0);
    idle(1);

    // reset while the three-wait-state instance sits in WAIT
    @(negedge clk);
    sq.push_back('{1, 1'b1, 5'h02, 32'h0000_0077});
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h02; pwdata = 32'h77;
    @(negedge clk); penable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 PRESET = 1'b1;
    #1 check_reset("reset_wait");
    psel = '0; penable = 1'b0;
    for (int k = 0; k < 3; k++) last_rd[k] = '0;
    @(negedge clk); PRESET = 1'b0;
    idle(2);
    xfer(1, 1, 5'h02, 32'h0000_0077, 32'h0, 0, 0, 4, 32'h0, 0);
    idle(3);

    checks++;
    if (sq.size() != 0) begin
      failures++;
      $display("FAIL strobe_missing: got %0d unseen strobes, required 0", sq.size());
    end
    checks++;
    if (rq.size() != 0) begin
      failures++;
      $display("FAIL pready_missing: got %0d unseen responses, required 0", rq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
